axis_video_monitor: RTL and testbench

Synthesisable AXI4-Stream video sink/monitor that generates `tready` back-pressure in runtime-selectable modes and checks frame framing (SOF on `tuser`, EOL on `tlast`) against a parametrised X×Y geometry. It also counts every framing and timeout error in saturating counters and produces a per-frame data checksum. It attaches to the output stream of `pixel_generator`, replacing simulation-only `$display` checking, so the checks can run both in the bench and on hardware through the status outputs.

---
 rtl/axis_video_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_axis_video_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_monitor.sv
// AXI4-Stream video sink: generates tready back-pressure, checks SOF/EOL framing
// against an X_SIZE x Y_SIZE geometry, counts errors and sums each frame's data.
module axis_video_monitor #(
  parameter int          X_SIZE   = 480,
  parameter int          Y_SIZE   = 480,
  parameter int          TIMEOUT  = 1000,
  parameter logic [32:0] RND_SEED = 33'd1246504138,
  parameter int          ERR_W    = 16,
  parameter int          FRM_W    = 16
) (
  input  logic                        clk,
  input  logic                        axi_resetn,
  input  logic [1:0]                  mode,
  input  logic                        clear_errors,
  input  logic [31:0]                 tdata,
  input  logic                        tvalid,
  input  logic                        tuser,
  input  logic                        tlast,
  output logic                        tready,
  output logic [$clog2(X_SIZE)-1:0]   x_pos,
  output logic [$clog2(Y_SIZE)-1:0]   y_pos,
  output logic [FRM_W-1:0]            frame_count,
  output logic                        frame_done,
  output logic [31:0]                 frame_checksum,
  output logic [ERR_W-1:0]            err_sof_missing,
  output logic [ERR_W-1:0]            err_sof_unexpected,
  output logic [ERR_W-1:0]            err_eol_missing,
  output logic [ERR_W-1:0]            err_eol_unexpected,
  output logic [ERR_W-1:0]            err_timeout,
  output logic                        err_any
);

  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(TIMEOUT - 1);

  localparam int E_SOF_MISS  = 0;
  localparam int E_SOF_UNEXP = 1;
  localparam int E_EOL_MISS  = 2;
  localparam int E_EOL_UNEXP = 3;
  localparam int E_TIMEOUT   = 4;

  logic [32:0]      prbs_q, prbs_d;
  logic             tready_q, tready_d;
  logic [XW-1:0]    x_q, x_d, x_eff;
  logic [YW-1:0]    y_q, y_d, y_eff;
  logic [FRM_W-1:0] frame_count_q, frame_count_d;
  logic [31:0]      acc_q, acc_d, acc_eff, acc_sum;
  logic [31:0]      checksum_q, checksum_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_bad_q, frame_bad_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [ERR_W-1:0] err_q [5];
  logic [ERR_W-1:0] err_d [5];
  logic             err_any_q, err_any_d;

  logic       beat;
  logic       line_end;
  logic       eol_ok;
  logic       origin;
  logic       prev_bad;
  logic       beat_err;
  logic [4:0] ev;

  // Handshake: a beat is tvalid && tready on a rising edge; tdata/tuser/tlast
  // are ignored otherwise. tready is registered and never depends on tvalid combinationally.
  always_comb begin
    prbs_d = {prbs_q[31:0], prbs_q[32] ^ ~prbs_q[19]};
    case (mode)
      2'd0:    tready_d = 1'b1;
      2'd1:    tready_d = prbs_q[32];
      2'd2:    tready_d = tvalid && !tready_q;
      default: tready_d = 1'b0;
    endcase

    beat          = tvalid && tready_q;
    ev            = '0;
    x_d           = x_q;
    y_d           = y_q;
    acc_d         = acc_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    checksum_d    = checksum_q;
    frame_bad_d   = frame_bad_q;
    x_eff         = x_q;
    y_eff         = y_q;
    acc_eff       = acc_q;
    acc_sum       = '0;
    line_end      = 1'b0;
    eol_ok        = 1'b0;
    origin        = 1'b0;
    prev_bad      = 1'b0;
    beat_err      = 1'b0;

    if (beat) begin
      if (x_q == '0 && y_q == '0) begin
        if (tuser) frame_count_d = frame_count_q + FRM_W'(1);
        else       ev[E_SOF_MISS] = 1'b1;
      end else if (tuser) begin
        // Resync: this beat becomes word 0 of line 0 of a new frame.
        ev[E_SOF_UNEXP] = 1'b1;
        frame_count_d   = frame_count_q + FRM_W'(1);
        x_eff           = '0;
        y_eff           = '0;
        acc_eff         = '0;
      end

      acc_sum = acc_eff + tdata;
      origin  = (x_eff == '0) && (y_eff == '0);

      if (x_eff == X_LAST) begin
        line_end = 1'b1;
        eol_ok   = tlast;
        if (!tlast) ev[E_EOL_MISS] = 1'b1;
      end else if (tlast) begin
        line_end        = 1'b1;
        ev[E_EOL_UNEXP] = 1'b1;
      end

      beat_err    = |ev[3:0];
      prev_bad    = origin ? 1'b0 : frame_bad_q;
      x_d         = line_end ? '0 : x_eff + XW'(1);
      y_d         = y_eff;
      acc_d       = acc_sum;
      frame_bad_d = prev_bad | beat_err;

      if (line_end) begin
        if (y_eff == Y_LAST) begin
          y_d         = '0;
          acc_d       = '0;
          frame_bad_d = 1'b0;
          // Only a frame with no framing error on any of its beats completes.
          if (eol_ok && !beat_err && !prev_bad) begin
            frame_done_d = 1'b1;
            checksum_d   = acc_sum;
          end
        end else begin
          y_d = y_eff + YW'(1);
        end
      end
    end

    if (tvalid) begin
      idle_d = '0;
    end else if (idle_q == I_LAST) begin
      idle_d        = '0;
      ev[E_TIMEOUT] = 1'b1;
    end else begin
      idle_d = idle_q + IW'(1);
    end

    for (int i = 0; i < 5; i++) begin
      if (clear_errors)                    err_d[i] = '0;
      else if (ev[i] && (err_q[i] != '1))  err_d[i] = err_q[i] + ERR_W'(1);
      else                                 err_d[i] = err_q[i];
    end
    err_any_d = clear_errors ? 1'b0 : (err_any_q | (|ev));
  end

  always_ff @(posedge clk) begin
    if (!axi_resetn) begin
      prbs_q        <= RND_SEED;
      tready_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      acc_q         <= '0;
      checksum_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_bad_q   <= 1'b0;
      idle_q        <= '0;
      err_any_q     <= 1'b0;
      for (int i = 0; i < 5; i++) err_q[i] <= '0;
    end else begin
      prbs_q        <= prbs_d;
      tready_q      <= tready_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      acc_q         <= acc_d;
      checksum_q    <= checksum_d;
      frame_done_q  <= frame_done_d;
      frame_bad_q   <= frame_bad_d;
      idle_q        <= idle_d;
      err_any_q     <= err_any_d;
      for (int i = 0; i < 5; i++) err_q[i] <= err_d[i];
    end
  end

  assign tready             = tready_q;
  assign x_pos              = x_q;
  assign y_pos              = y_q;
  assign frame_count        = frame_count_q;
  assign frame_done         = frame_done_q;
  assign frame_checksum     = checksum_q;
  assign err_sof_missing    = err_q[E_SOF_MISS];
  assign err_sof_unexpected = err_q[E_SOF_UNEXP];
  assign err_eol_missing    = err_q[E_EOL_MISS];
  assign err_eol_unexpected = err_q[E_EOL_UNEXP];
  assign err_timeout        = err_q[E_TIMEOUT];
  assign err_any            = err_any_q;

endmodule

// File: tb/tb_axis_video_monitor.sv
// Directed bench for axis_video_monitor with a 4x2 frame geometry and TIMEOUT=8.
module tb_axis_video_monitor;

  localparam logic [32:0] SEED = 33'd1246504138;

  logic        clk = 1'b0;
  logic        axi_resetn;
  logic [1:0]  mode;
  logic        clear_errors;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        tready;
  logic [1:0]  x_pos;
  logic [0:0]  y_pos;
  logic [15:0] frame_count;
  logic        frame_done;
  logic [31:0] frame_checksum;
  logic [15:0] err_sof_missing;
  logic [15:0] err_sof_unexpected;
  logic [15:0] err_eol_missing;
  logic [15:0] err_eol_unexpected;
  logic [15:0] err_timeout;
  logic        err_any;

  int checks   = 0;
  int failures = 0;

  logic [32:0] prbs_m;
  logic [32:0] prbs_prev;

  axis_video_monitor #(
    .X_SIZE(4), .Y_SIZE(2), .TIMEOUT(8), .RND_SEED(SEED), .ERR_W(16), .FRM_W(16)
  ) dut (
    .clk(clk), .axi_resetn(axi_resetn), .mode(mode), .clear_errors(clear_errors),
    .tdata(tdata), .tvalid(tvalid), .tuser(tuser), .tlast(tlast), .tready(tready),
    .x_pos(x_pos), .y_pos(y_pos), .frame_count(frame_count), .frame_done(frame_done),
    .frame_checksum(frame_checksum), .err_sof_missing(err_sof_missing),
    .err_sof_unexpected(err_sof_unexpected), .err_eol_missing(err_eol_missing),
    .err_eol_unexpected(err_eol_unexpected), .err_timeout(err_timeout), .err_any(err_any)
  );

  // Clock and reference ready LFSR
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!axi_resetn) begin
      prbs_m    <= SEED;
      prbs_prev <= SEED;
    end else begin
      prbs_prev <= prbs_m;
      prbs_m    <= {prbs_m[31:0], prbs_m[32] ^ ~prbs_m[19]};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_errs(input string tag, input int sm, input int su, input int em,
                          input int eu, input int to, input logic any);
    chk({tag, "_sof_missing"}, err_sof_missing, sm);
    chk({tag, "_sof_unexpected"}, err_sof_unexpected, su);
    chk({tag, "_eol_missing"}, err_eol_missing, em);
    chk({tag, "_eol_unexpected"}, err_eol_unexpected, eu);
    chk({tag, "_timeout"}, err_timeout, to);
    chk({tag, "_err_any"}, err_any, any);
  endtask

  // Drive one beat and wait until it is accepted; returns at the negedge after acceptance.
  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    logic b;
    int   n;
    n      = 0;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tvalid = 1'b1;
    do begin
      b = tready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!b && n < 50);
    chk("beat_accepted", b, 1'b1);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input int mul);
    for (int i = 0; i < 8; i++)
      send_beat(32'(mul * (i + 1)), (i == 0), ((i % 4) == 3));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tready"}, tready, 1'b0);
    chk({tag, "_x"}, x_pos, 0);
    chk({tag, "_y"}, y_pos, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_checksum"}, frame_checksum, 0);
    chk_errs(tag, 0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    logic exp_r;
    axi_resetn   = 1'b0;
    mode         = 2'd0;
    clear_errors = 1'b0;
    tdata        = '0;
    tvalid       = 1'b0;
    tuser        = 1'b0;
    tlast        = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");

    // Clean frames, data 1..8
    axi_resetn = 1'b1;
    @(negedge clk);
    send_frame(1);
    chk("clean1_done", frame_done, 1'b1);
    chk("clean1_checksum", frame_checksum, 36);
    chk("clean1_count", frame_count, 1);
    send_frame(1);
    chk("clean2_done", frame_done, 1'b1);
    chk("clean2_checksum", frame_checksum, 36);
    chk("clean2_count", frame_count, 2);
    @(negedge clk);
    chk("clean_done_pulse_low", frame_done, 1'b0);
    chk("clean_x", x_pos, 0);
    chk("clean_y", y_pos, 0);
    chk_errs("clean", 0, 0, 0, 0, 0, 1'b0);

    // Missing EOL on word 3 of line 0
    send_beat(1, 1'b1, 1'b0);
    send_beat(2, 1'b0, 1'b0);
    send_beat(3, 1'b0, 1'b0);
    send_beat(4, 1'b0, 1'b0);
    chk_errs("eolmiss", 0, 0, 1, 0, 0, 1'b1);
    chk("eolmiss_x", x_pos, 0);
    chk("eolmiss_y", y_pos, 1);
    send_beat(5, 1'b0, 1'b0);
    send_beat(6, 1'b0, 1'b0);
    send_beat(7, 1'b0, 1'b0);
    send_beat(8, 1'b0, 1'b1);
    chk("eolmiss_no_done", frame_done, 1'b0);
    chk("eolmiss_count", frame_count, 3);
    chk("eolmiss_checksum_held", frame_checksum, 36);
    chk("eolmiss_y_wrap", y_pos, 0);

    // Unexpected SOF at x=2, then unexpected EOL at x=1
    send_beat(10, 1'b1, 1'b0);
    send_beat(20, 1'b0, 1'b0);
    send_beat(5, 1'b1, 1'b0);
    chk("sofunexp_err", err_sof_unexpected, 1);
    chk("sofunexp_count", frame_count, 5);
    chk("sofunexp_x", x_pos, 1);
    chk("sofunexp_y", y_pos, 0);
    send_beat(6, 1'b0, 1'b1);
    chk("eolunexp_err", err_eol_unexpected, 1);
    chk("eolunexp_x", x_pos, 0);
    chk("eolunexp_y", y_pos, 1);
    send_beat(7, 1'b0, 1'b0);
    send_beat(8, 1'b0, 1'b0);
    send_beat(9, 1'b0, 1'b0);
    send_beat(10, 1'b0, 1'b1);
    chk("resync_no_done", frame_done, 1'b0);
    chk("resync_x", x_pos, 0);
    chk("resync_y", y_pos, 0);

    // Clean frame with data 2,4..16 after errors
    send_frame(2);
    chk("clean72_done", frame_done, 1'b1);
    chk("clean72_checksum", frame_checksum, 72);
    chk("clean72_count", frame_count, 6);

    // Missing SOF at origin
    send_beat(0, 1'b0, 1'b0);
    chk("sofmiss_err", err_sof_missing, 1);
    chk("sofmiss_x", x_pos, 1);

    // Timeout: idle counter cleared by one valid cycle, then 20 idle cycles
    mode = 2'd3;
    @(negedge clk);
    tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    repeat (20) @(negedge clk);
    chk("timeout_count", err_timeout, 2);
    chk_errs("pre_clear", 1, 1, 1, 1, 2, 1'b1);
    repeat (3) @(negedge clk);
    clear_errors = 1'b1;  // lands on the edge of the third timeout event
    @(negedge clk);
    clear_errors = 1'b0;
    chk_errs("clear", 0, 0, 0, 0, 0, 1'b0);

    // RANDOM mode against reference LFSR
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("random_tready", tready, prbs_prev[32]);
    end

    // AFTER_VALID with constant tvalid
    mode = 2'd2;
    @(negedge clk);
    chk("aftervalid_idle", tready, 1'b0);
    tdata  = 32'h55;
    tvalid = 1'b1;
    exp_r  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("aftervalid_tready", tready, exp_r);
      exp_r = ~exp_r;
    end

    // STALL: no beats even with SOF offered
    mode  = 2'd3;
    tuser = 1'b1;
    tlast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_tready", tready, 1'b0);
    end
    chk("stall_count", frame_count, 6);
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;

    // Reach x=2,y=1 then reset mid-frame
    mode = 2'd0;
    @(negedge clk);
    send_beat(1, 1'b1, 1'b0);
    send_beat(2, 1'b0, 1'b1);
    send_beat(3, 1'b0, 1'b0);
    send_beat(4, 1'b0, 1'b0);
    chk("premid_x", x_pos, 2);
    chk("premid_y", y_pos, 1);
    chk("premid_count", frame_count, 7);
    axi_resetn = 1'b0;
    @(negedge clk);
    chk_reset_values("midreset");
    axi_resetn = 1'b1;
    @(negedge clk);
    send_frame(1);
    chk("post_reset_count", frame_count, 1);
    chk("post_reset_done", frame_done, 1'b1);
    chk("post_reset_checksum", frame_checksum, 36);
    chk_errs("post_reset", 0, 0, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
